// File: rtl/memwb_block_pkg.sv
// Shared constants and forwarding-select encoding for the MEM/WB back end.
package memwb_block_pkg;

  localparam int XLEN     = 32;
  localparam int REGADDRW = 5;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // A matching load in MEM has no usable value yet, so it blocks the older WB copy too.
  function automatic logic [1:0] fwd_select(input logic mem_hit, input logic mem_is_load,
                                            input logic wb_hit);
    fwd_sel_e sel;
    if (mem_hit) begin
      sel = mem_is_load ? FWD_REG : FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_REG;
    end
    return sel;
  endfunction

endpackage

// File: rtl/memwb_block_forward_unit.sv
// Combinational EX-stage operand forwarding selects and the load-use stall request.
module memwb_block_forward_unit #(
  parameter int REGADDRW = memwb_block_pkg::REGADDRW
) (
  input  logic                mem_valid,
  input  logic                mem_reg_write,
  input  logic                mem_dmem_reb,
  input  logic [REGADDRW-1:0] mem_rd,
  input  logic                wb_write,
  input  logic [REGADDRW-1:0] wb_rd,
  input  logic                ex_valid,
  input  logic                ex_reg_write,
  input  logic                ex_dmem_reb,
  input  logic [REGADDRW-1:0] ex_rd,
  input  logic [REGADDRW-1:0] ifid_rs1,
  input  logic [REGADDRW-1:0] ifid_rs2,
  input  logic [REGADDRW-1:0] idex_rs1,
  input  logic [REGADDRW-1:0] idex_rs2,
  output logic [1:0]          forward_a,
  output logic [1:0]          forward_b,
  output logic                load_use_stall
);
  import memwb_block_pkg::*;

  logic mem_src;
  logic ex_load_src;

  always_comb begin
    mem_src     = mem_valid & mem_reg_write & (mem_rd != '0);
    ex_load_src = ex_valid & ~ex_dmem_reb & ex_reg_write & (ex_rd != '0);

    forward_a = fwd_select(mem_src & (mem_rd == idex_rs1), ~mem_dmem_reb,
                           wb_write & (wb_rd == idex_rs1));
    forward_b = fwd_select(mem_src & (mem_rd == idex_rs2), ~mem_dmem_reb,
                           wb_write & (wb_rd == idex_rs2));

    load_use_stall = ex_load_src & ((ex_rd == ifid_rs1) | (ex_rd == ifid_rs2));
  end

endmodule

// File: rtl/memwb_block.sv
// EX/MEM and MEM/WB pipeline registers, writeback mux and regfile write port.
module memwb_block #(
  parameter int XLEN     = memwb_block_pkg::XLEN,
  parameter int REGADDRW = memwb_block_pkg::REGADDRW
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EXValid,
  input  logic                EXRegWrite,
  input  logic [REGADDRW-1:0] EXrd,
  input  logic [XLEN-1:0]     EXALUOUT,
  input  logic                EXDmem1ALUOUT,
  input  logic                EXDmemREB,
  input  logic [XLEN-1:0]     DmemRdata,
  input  logic [REGADDRW-1:0] IFIDrs1,
  input  logic [REGADDRW-1:0] IFIDrs2,
  input  logic [REGADDRW-1:0] IDEXrs1,
  input  logic [REGADDRW-1:0] IDEXrs2,
  output logic [XLEN-1:0]     MEMALUOUT,
  output logic                RegWrite,
  output logic [REGADDRW-1:0] rd,
  output logic [XLEN-1:0]     regfile_indata,
  output logic [1:0]          ForwardA,
  output logic [1:0]          ForwardB,
  output logic                LoadUseStall
);

  logic                mem_valid_d, mem_valid_q;
  logic                mem_reg_write_d, mem_reg_write_q;
  logic [REGADDRW-1:0] mem_rd_d, mem_rd_q;
  logic [XLEN-1:0]     mem_aluout_d, mem_aluout_q;
  logic                mem_sel_dmem_d, mem_sel_dmem_q;
  logic                mem_dmem_reb_d, mem_dmem_reb_q;

  logic                wb_valid_d, wb_valid_q;
  logic                wb_reg_write_d, wb_reg_write_q;
  logic [REGADDRW-1:0] wb_rd_d, wb_rd_q;
  logic [XLEN-1:0]     wb_data_d, wb_data_q;

  always_comb begin
    // A bubble drops its write enable here so it can neither write nor forward later.
    mem_valid_d     = EXValid;
    mem_reg_write_d = EXValid & EXRegWrite;
    mem_rd_d        = EXrd;
    mem_aluout_d    = EXALUOUT;
    mem_sel_dmem_d  = EXDmem1ALUOUT;
    mem_dmem_reb_d  = EXDmemREB;

    wb_valid_d      = mem_valid_q;
    wb_reg_write_d  = mem_reg_write_q;
    wb_rd_d         = mem_rd_q;
    wb_data_d       = mem_sel_dmem_q ? DmemRdata : mem_aluout_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mem_valid_q     <= 1'b0;
      mem_reg_write_q <= 1'b0;
      mem_rd_q        <= '0;
      mem_aluout_q    <= '0;
      mem_sel_dmem_q  <= 1'b0;
      mem_dmem_reb_q  <= 1'b1;
      wb_valid_q      <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_rd_q         <= '0;
      wb_data_q       <= '0;
    end else begin
      mem_valid_q     <= mem_valid_d;
      mem_reg_write_q <= mem_reg_write_d;
      mem_rd_q        <= mem_rd_d;
      mem_aluout_q    <= mem_aluout_d;
      mem_sel_dmem_q  <= mem_sel_dmem_d;
      mem_dmem_reb_q  <= mem_dmem_reb_d;
      wb_valid_q      <= wb_valid_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_rd_q         <= wb_rd_d;
      wb_data_q       <= wb_data_d;
    end
  end

  // Writes to x0 never reach the regfile, which also keeps them out of WB forwarding.
  assign RegWrite       = wb_valid_q & wb_reg_write_q & (wb_rd_q != '0);
  assign rd             = wb_rd_q;
  assign regfile_indata = wb_data_q;
  assign MEMALUOUT      = mem_aluout_q;

  memwb_block_forward_unit #(
    .REGADDRW(REGADDRW)
  ) u_forward_unit (
    .mem_valid     (mem_valid_q),
    .mem_reg_write (mem_reg_write_q),
    .mem_dmem_reb  (mem_dmem_reb_q),
    .mem_rd        (mem_rd_q),
    .wb_write      (RegWrite),
    .wb_rd         (wb_rd_q),
    .ex_valid      (EXValid),
    .ex_reg_write  (EXRegWrite),
    .ex_dmem_reb   (EXDmemREB),
    .ex_rd         (EXrd),
    .ifid_rs1      (IFIDrs1),
    .ifid_rs2      (IFIDrs2),
    .idex_rs1      (IDEXrs1),
    .idex_rs2      (IDEXrs2),
    .forward_a     (ForwardA),
    .forward_b     (ForwardB),
    .load_use_stall(LoadUseStall)
  );

endmodule

// File: tb/tb_memwb_block.sv
// Scenario tasks plus a randomized run checked against an instruction-history model.
module tb_memwb_block;

  logic        CLK = 1'b0;
  logic        RST;
  logic        EXValid, EXRegWrite, EXDmem1ALUOUT, EXDmemREB;
  logic [4:0]  EXrd, IFIDrs1, IFIDrs2, IDEXrs1, IDEXrs2;
  logic [31:0] EXALUOUT, DmemRdata;
  logic [31:0] MEMALUOUT, regfile_indata;
  logic        RegWrite, LoadUseStall;
  logic [4:0]  rd;
  logic [1:0]  ForwardA, ForwardB;

  int errors = 0;
  int checks = 0;

  memwb_block dut (
    .CLK(CLK), .RST(RST), .EXValid(EXValid), .EXRegWrite(EXRegWrite), .EXrd(EXrd),
    .EXALUOUT(EXALUOUT), .EXDmem1ALUOUT(EXDmem1ALUOUT), .EXDmemREB(EXDmemREB),
    .DmemRdata(DmemRdata), .IFIDrs1(IFIDrs1), .IFIDrs2(IFIDrs2), .IDEXrs1(IDEXrs1),
    .IDEXrs2(IDEXrs2), .MEMALUOUT(MEMALUOUT), .RegWrite(RegWrite), .rd(rd),
    .regfile_indata(regfile_indata), .ForwardA(ForwardA), .ForwardB(ForwardB),
    .LoadUseStall(LoadUseStall)
  );

  always #5 CLK = ~CLK;

  // Model: the two most recently issued instructions; [0] is in MEM, [1] in WB.
  typedef struct {
    logic        valid;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic        is_load;
    logic [31:0] rdata;
  } instr_t;
  instr_t hist[$];

  function automatic instr_t mk_instr(input logic v, input logic w, input logic [4:0] r,
                                      input logic [31:0] a, input logic ld);
    instr_t e;
    e.valid = v; e.rw = w; e.rd = r; e.alu = a; e.is_load = ld; e.rdata = 32'h0;
    return e;
  endfunction

  task automatic model_edge();
    if (RST) begin
      hist.delete();
      hist.push_front(mk_instr(1'b0, 1'b0, 5'd0, 32'h0, 1'b0));
      hist.push_front(mk_instr(1'b0, 1'b0, 5'd0, 32'h0, 1'b0));
    end else begin
      if (hist.size() > 0) hist[0].rdata = DmemRdata;
      hist.push_front(mk_instr(EXValid, EXRegWrite, EXrd, EXALUOUT, EXDmem1ALUOUT));
      while (hist.size() > 2) void'(hist.pop_back());
    end
  endtask

  function automatic logic m_write();
    return hist[1].valid && hist[1].rw && (hist[1].rd != 5'd0);
  endfunction

  function automatic logic [31:0] m_data();
    return hist[1].is_load ? hist[1].rdata : hist[1].alu;
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (hist[0].valid && hist[0].rw && hist[0].rd != 5'd0 && hist[0].rd == rs)
      return hist[0].is_load ? 2'b00 : 2'b10;
    if (m_write() && hist[1].rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic m_stall();
    return EXValid && EXDmem1ALUOUT && !EXDmemREB && EXRegWrite && EXrd != 5'd0 &&
           (EXrd == IFIDrs1 || EXrd == IFIDrs2);
  endfunction

  task automatic tick();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  task automatic idle();
    EXValid = 1'b0; EXRegWrite = 1'b0; EXrd = 5'd0; EXALUOUT = 32'h0;
    EXDmem1ALUOUT = 1'b0; EXDmemREB = 1'b1; DmemRdata = 32'h0;
    IFIDrs1 = 5'd0; IFIDrs2 = 5'd0; IDEXrs1 = 5'd0; IDEXrs2 = 5'd0;
  endtask

  task automatic issue(input logic [4:0] r, input logic w, input logic [31:0] a,
                       input logic ld);
    EXValid = 1'b1; EXRegWrite = w; EXrd = r; EXALUOUT = a;
    EXDmem1ALUOUT = ld; EXDmemREB = ~ld;
  endtask

  task automatic flush();
    idle(); tick(); tick();
  endtask

  task automatic test_reset();
    idle(); RST = 1'b1;
    issue(5'd4, 1'b1, 32'h55, 1'b0); IDEXrs1 = 5'd4;
    for (int c = 0; c < 2; c++) begin
      tick(); #1;
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite c%0d got=%b exp=0", c, RegWrite); end
      checks++; if (MEMALUOUT !== 32'h0) begin errors++; $display("FAIL reset_memaluout c%0d got=%h exp=0", c, MEMALUOUT); end
      checks++; if (ForwardA !== 2'b00) begin errors++; $display("FAIL reset_fwda c%0d got=%b exp=00", c, ForwardA); end
    end
    RST = 1'b0; EXValid = 1'b0;
    tick(); #1;
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_release_regwrite got=%b exp=0", RegWrite); end
    issue(5'd6, 1'b1, 32'h66, 1'b0);
    tick(); #1;
    EXValid = 1'b0; RST = 1'b1;
    checks++; if (MEMALUOUT !== 32'h66) begin errors++; $display("FAIL kill_mem_before got=%h exp=66", MEMALUOUT); end
    tick(); #1;
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL kill_regwrite got=%b exp=0", RegWrite); end
    checks++; if (MEMALUOUT !== 32'h0) begin errors++; $display("FAIL kill_memaluout got=%h exp=0", MEMALUOUT); end
    RST = 1'b0;
    tick(); #1;
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL kill_after_regwrite got=%b exp=0", RegWrite); end
    $display("txn reset done");
  endtask

  task automatic test_alu_chain();
    flush();
    issue(5'd5, 1'b1, 32'h11, 1'b0);
    tick();
    issue(5'd8, 1'b0, 32'h22, 1'b0); IDEXrs1 = 5'd5; #1;
    checks++; if (ForwardA !== 2'b10) begin errors++; $display("FAIL chain_fwda_mem got=%b exp=10", ForwardA); end
    checks++; if (MEMALUOUT !== 32'h11) begin errors++; $display("FAIL chain_memaluout got=%h exp=11", MEMALUOUT); end
    tick();
    issue(5'd9, 1'b0, 32'h33, 1'b0); IDEXrs1 = 5'd5; #1;
    checks++; if (ForwardA !== 2'b01) begin errors++; $display("FAIL chain_fwda_wb got=%b exp=01", ForwardA); end
    checks++; if (regfile_indata !== 32'h11) begin errors++; $display("FAIL chain_wbdata got=%h exp=11", regfile_indata); end
    checks++; if (rd !== 5'd5 || RegWrite !== 1'b1) begin errors++; $display("FAIL chain_write got rd=%0d we=%b exp rd=5 we=1", rd, RegWrite); end
    $display("txn alu_chain done");
  endtask

  task automatic test_load_use();
    flush();
    issue(5'd7, 1'b1, 32'h100, 1'b1); IFIDrs2 = 5'd7; #1;
    checks++; if (LoadUseStall !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b exp=1", LoadUseStall); end
    tick();
    EXValid = 1'b0; DmemRdata = 32'hDEADBEEF; #1;
    checks++; if (LoadUseStall !== 1'b0) begin errors++; $display("FAIL lu_stall_bubble got=%b exp=0", LoadUseStall); end
    tick();
    DmemRdata = 32'h12345678; IFIDrs2 = 5'd0;
    issue(5'd10, 1'b1, 32'h0, 1'b0); IDEXrs2 = 5'd7; #1;
    checks++; if (ForwardB !== 2'b01) begin errors++; $display("FAIL lu_fwdb got=%b exp=01", ForwardB); end
    checks++; if (regfile_indata !== 32'hDEADBEEF) begin errors++; $display("FAIL lu_wbdata got=%h exp=deadbeef", regfile_indata); end
    checks++; if (rd !== 5'd7 || RegWrite !== 1'b1) begin errors++; $display("FAIL lu_write got rd=%0d we=%b exp rd=7 we=1", rd, RegWrite); end
    $display("txn load_use done");
  endtask

  task automatic test_double_hazard();
    flush();
    issue(5'd3, 1'b1, 32'h1, 1'b0); tick();
    issue(5'd3, 1'b1, 32'h2, 1'b0); tick();
    issue(5'd11, 1'b0, 32'h0, 1'b0); IDEXrs1 = 5'd3; #1;
    checks++; if (ForwardA !== 2'b10) begin errors++; $display("FAIL dbl_fwda got=%b exp=10", ForwardA); end
    checks++; if (MEMALUOUT !== 32'h2) begin errors++; $display("FAIL dbl_memaluout got=%h exp=2", MEMALUOUT); end
    checks++; if (regfile_indata !== 32'h1 || RegWrite !== 1'b1) begin errors++; $display("FAIL dbl_wb got data=%h we=%b exp data=1 we=1", regfile_indata, RegWrite); end
    $display("txn double_hazard done");
  endtask

  task automatic test_x0();
    flush();
    issue(5'd0, 1'b1, 32'h77, 1'b0); tick();
    issue(5'd12, 1'b0, 32'h0, 1'b0); IDEXrs1 = 5'd0; #1;
    checks++; if (ForwardA !== 2'b00) begin errors++; $display("FAIL x0_fwda_mem got=%b exp=00", ForwardA); end
    tick(); #1;
    checks++; if (ForwardA !== 2'b00) begin errors++; $display("FAIL x0_fwda_wb got=%b exp=00", ForwardA); end
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL x0_regwrite got=%b exp=0", RegWrite); end
    $display("txn x0 done");
  endtask

  task automatic test_bubble();
    flush();
    EXValid = 1'b0; EXRegWrite = 1'b1; EXrd = 5'd9; EXALUOUT = 32'h99;
    tick();
    issue(5'd13, 1'b0, 32'h0, 1'b0); IDEXrs2 = 5'd9; #1;
    checks++; if (ForwardB !== 2'b00) begin errors++; $display("FAIL bub_fwdb_mem got=%b exp=00", ForwardB); end
    tick(); #1;
    checks++; if (ForwardB !== 2'b00) begin errors++; $display("FAIL bub_fwdb_wb got=%b exp=00", ForwardB); end
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL bub_regwrite got=%b exp=0", RegWrite); end
    $display("txn bubble done");
  endtask

  task automatic test_random();
    logic ld;
    idle(); RST = 1'b1; tick(); RST = 1'b0;
    for (int n = 0; n < 400; n++) begin
      RST = ($urandom_range(0, 39) == 0);
      ld = ($urandom_range(0, 2) == 0);
      issue(5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom, ld);
      EXValid = ($urandom_range(0, 3) != 0);
      DmemRdata = $urandom;
      IFIDrs1 = 5'($urandom_range(0, 7)); IFIDrs2 = 5'($urandom_range(0, 7));
      IDEXrs1 = 5'($urandom_range(0, 7)); IDEXrs2 = 5'($urandom_range(0, 7));
      #1;
      checks++; if (RegWrite !== m_write()) begin errors++; $display("FAIL rnd_regwrite n=%0d got=%b exp=%b", n, RegWrite, m_write()); end
      checks++; if (rd !== hist[1].rd) begin errors++; $display("FAIL rnd_rd n=%0d got=%0d exp=%0d", n, rd, hist[1].rd); end
      checks++; if (regfile_indata !== m_data()) begin errors++; $display("FAIL rnd_wbdata n=%0d got=%h exp=%h", n, regfile_indata, m_data()); end
      checks++; if (MEMALUOUT !== hist[0].alu) begin errors++; $display("FAIL rnd_memaluout n=%0d got=%h exp=%h", n, MEMALUOUT, hist[0].alu); end
      checks++; if (ForwardA !== m_fwd(IDEXrs1)) begin errors++; $display("FAIL rnd_fwda n=%0d got=%b exp=%b", n, ForwardA, m_fwd(IDEXrs1)); end
      checks++; if (ForwardB !== m_fwd(IDEXrs2)) begin errors++; $display("FAIL rnd_fwdb n=%0d got=%b exp=%b", n, ForwardB, m_fwd(IDEXrs2)); end
      checks++; if (LoadUseStall !== m_stall()) begin errors++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, LoadUseStall, m_stall()); end
      $display("txn %0d rst=%b v=%b rd=%0d ld=%b we=%b fa=%b fb=%b", n, RST, EXValid, EXrd, ld, RegWrite, ForwardA, ForwardB);
      tick();
    end
    RST = 1'b0;
  endtask

  initial begin
    idle(); RST = 1'b1;
    test_reset();
    test_alu_chain();
    test_load_use();
    test_double_hazard();
    test_x0();
    test_bubble();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
